// File: rtl/sdram_init_refresh_sequencer_if.sv
// Command bus and arbitration signals between the init/refresh sequencer and the SDRAM command mux.
interface sdram_init_refresh_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_code;
    logic [12:0] cmd_addr;
    logic [1:0]  cmd_ba;
    logic        bus_req;
    logic        bus_gnt;
    logic        init_done;
    logic        refresh_urgent;

    modport master (
        output cmd_valid, cmd_code, cmd_addr, cmd_ba, bus_req, init_done, refresh_urgent,
        input  cmd_ready, bus_gnt
    );

    modport slave (
        input  cmd_valid, cmd_code, cmd_addr, cmd_ba, bus_req, init_done, refresh_urgent,
        output cmd_ready, bus_gnt
    );
endinterface

// File: rtl/sdram_init_refresh_sequencer.sv
// Power-up initialisation and periodic auto-refresh for the sdramA SDRAM; after init it
// borrows the shared command bus through bus_req/bus_gnt and tracks postponed refreshes.
module sdram_init_refresh_sequencer #(
    parameter int          INIT_WAIT_CYCLES = 5000,
    parameter int          REFRESH_INTERVAL = 390,
    parameter int          TRP              = 2,
    parameter int          TRFC             = 4,
    parameter int          TMRD             = 2,
    parameter int          INIT_REFRESHES   = 2,
    parameter int          MAX_PENDING      = 8,
    parameter logic [12:0] MODE_REG         = 13'h030
) (
    input logic clk,
    input logic reset,
    sdram_init_refresh_sequencer_if.master sdram
);
    localparam int INIT_W   = $clog2(INIT_WAIT_CYCLES + 1);
    localparam int TIMER_W  = $clog2(REFRESH_INTERVAL + 1);
    localparam int PEND_W   = $clog2(MAX_PENDING + 1);
    localparam int REFS_W   = $clog2(INIT_REFRESHES + 1);
    localparam int WAIT_MAX = (TRP > TRFC) ? ((TRP > TMRD) ? TRP : TMRD)
                                           : ((TRFC > TMRD) ? TRFC : TMRD);
    localparam int WAIT_W   = $clog2(WAIT_MAX + 2);

    localparam logic [INIT_W-1:0]  INIT_LAST  = INIT_W'(INIT_WAIT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(REFRESH_INTERVAL - 1);
    localparam logic [PEND_W-1:0]  PEND_MAX   = PEND_W'(MAX_PENDING);
    localparam logic [REFS_W-1:0]  REFS_LAST  = REFS_W'(INIT_REFRESHES);
    localparam logic [WAIT_W-1:0]  WAIT_TRP   = WAIT_W'(TRP);
    localparam logic [WAIT_W-1:0]  WAIT_TRFC  = WAIT_W'(TRFC);
    localparam logic [WAIT_W-1:0]  WAIT_TMRD  = WAIT_W'(TMRD);
    localparam logic [WAIT_W-1:0]  WAIT_ONE   = WAIT_W'(1);

    localparam logic [2:0]  CMD_NOP  = 3'b111;
    localparam logic [2:0]  CMD_PRE  = 3'b010;
    localparam logic [2:0]  CMD_REF  = 3'b001;
    localparam logic [2:0]  CMD_LMR  = 3'b000;
    localparam logic [12:0] ADDR_ALL = 13'h400;

    typedef enum logic [3:0] {
        INIT_WAIT, INIT_PRE, INIT_TRP, INIT_REF, INIT_TRFC, INIT_MRS, INIT_TMRD,
        IDLE, REQ, REF_PRE, REF_TRP, REF_CMD, REF_TRFC
    } state_t;

    state_t             state, state_next;
    logic [INIT_W-1:0]  init_cnt;
    logic [TIMER_W-1:0] timer;
    logic [PEND_W-1:0]  pending, pending_next;
    logic [REFS_W-1:0]  init_refs;
    logic [WAIT_W-1:0]  wait_cnt, wait_load;
    logic               wait_start, wait_done, tick;
    logic               refresh_taken, init_ref_taken;
    logic               init_done_q, urgent_q;
    logic               cmd_valid_c, bus_req_c;
    logic [2:0]         cmd_code_c;
    logic [12:0]        cmd_addr_c;
    logic [1:0]         cmd_ba_c;

    // The wait counter hits zero on the edge that leaves a wait state, giving N+1 cycles to the next command.
    assign wait_done = (wait_cnt <= WAIT_ONE);
    assign tick      = init_done_q && (timer == TIMER_LAST);

    always_ff @(posedge clk) begin
        if (reset) state <= INIT_WAIT;
        else       state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            init_cnt    <= '0;
            timer       <= '0;
            pending     <= '0;
            init_refs   <= '0;
            wait_cnt    <= '0;
            init_done_q <= 1'b0;
            urgent_q    <= 1'b0;
        end else begin
            if (state == INIT_WAIT) init_cnt <= init_cnt + 1'b1;
            if (wait_start)            wait_cnt <= wait_load;
            else if (wait_cnt != '0)   wait_cnt <= wait_cnt - 1'b1;
            if (init_ref_taken) init_refs <= init_refs + 1'b1;
            if (state == INIT_TMRD && state_next == IDLE) init_done_q <= 1'b1;
            // The interval timer stays parked at zero until init completes, then free-runs.
            if (!init_done_q || timer == TIMER_LAST) timer <= '0;
            else                                     timer <= timer + 1'b1;
            pending  <= pending_next;
            urgent_q <= (pending_next == PEND_MAX);
        end
    end

    // A tick arriving together with an accepted refresh cancels out, even at saturation.
    always_comb begin
        pending_next = pending;
        if (tick && !refresh_taken) begin
            if (pending != PEND_MAX) pending_next = pending + 1'b1;
        end else if (refresh_taken && !tick && pending != '0) begin
            pending_next = pending - 1'b1;
        end
    end

    always_comb begin
        state_next     = state;
        cmd_valid_c    = 1'b0;
        cmd_code_c     = CMD_NOP;
        cmd_addr_c     = '0;
        cmd_ba_c       = '0;
        bus_req_c      = 1'b0;
        wait_start     = 1'b0;
        wait_load      = '0;
        refresh_taken  = 1'b0;
        init_ref_taken = 1'b0;
        case (state)
            INIT_WAIT: if (init_cnt == INIT_LAST) state_next = INIT_PRE;
            INIT_PRE: begin
                cmd_valid_c = 1'b1;
                cmd_code_c  = CMD_PRE;
                cmd_addr_c  = ADDR_ALL;
                if (sdram.cmd_ready) begin
                    state_next = INIT_TRP;
                    wait_start = 1'b1;
                    wait_load  = WAIT_TRP;
                end
            end
            INIT_TRP: if (wait_done) state_next = INIT_REF;
            INIT_REF: begin
                cmd_valid_c = 1'b1;
                cmd_code_c  = CMD_REF;
                if (sdram.cmd_ready) begin
                    state_next     = INIT_TRFC;
                    wait_start     = 1'b1;
                    wait_load      = WAIT_TRFC;
                    init_ref_taken = 1'b1;
                end
            end
            INIT_TRFC: if (wait_done) state_next = (init_refs == REFS_LAST) ? INIT_MRS : INIT_REF;
            INIT_MRS: begin
                cmd_valid_c = 1'b1;
                cmd_code_c  = CMD_LMR;
                cmd_addr_c  = MODE_REG;
                if (sdram.cmd_ready) begin
                    state_next = INIT_TMRD;
                    wait_start = 1'b1;
                    wait_load  = WAIT_TMRD;
                end
            end
            INIT_TMRD: if (wait_done) state_next = IDLE;
            IDLE: if (pending != '0) state_next = REQ;
            REQ: begin
                bus_req_c = 1'b1;
                if (sdram.bus_gnt) state_next = REF_PRE;
            end
            REF_PRE: begin
                bus_req_c   = 1'b1;
                cmd_valid_c = 1'b1;
                cmd_code_c  = CMD_PRE;
                cmd_addr_c  = ADDR_ALL;
                if (sdram.cmd_ready) begin
                    state_next = REF_TRP;
                    wait_start = 1'b1;
                    wait_load  = WAIT_TRP;
                end
            end
            REF_TRP: begin
                bus_req_c = 1'b1;
                if (wait_done) state_next = REF_CMD;
            end
            REF_CMD: begin
                bus_req_c   = 1'b1;
                cmd_valid_c = 1'b1;
                cmd_code_c  = CMD_REF;
                if (sdram.cmd_ready) begin
                    state_next    = REF_TRFC;
                    wait_start    = 1'b1;
                    wait_load     = WAIT_TRFC;
                    refresh_taken = 1'b1;
                end
            end
            // Banks are still precharged after a refresh, so backlog is drained without another PRECHARGE.
            REF_TRFC: begin
                bus_req_c = 1'b1;
                if (wait_done) state_next = (pending != '0 && sdram.bus_gnt) ? REF_CMD : IDLE;
            end
            default: state_next = INIT_WAIT;
        endcase
    end

    assign sdram.cmd_valid      = cmd_valid_c;
    assign sdram.cmd_code       = cmd_code_c;
    assign sdram.cmd_addr       = cmd_addr_c;
    assign sdram.cmd_ba         = cmd_ba_c;
    assign sdram.bus_req        = bus_req_c;
    assign sdram.init_done      = init_done_q;
    assign sdram.refresh_urgent = urgent_q;
endmodule

// File: tb/tb_sdram_init_refresh_sequencer.sv
// Bench for the SDRAM init/refresh sequencer: init vector table, accepted-command scoreboard,
// and hand-written sequences for backpressure, refresh backlog, tick collision and mid-run reset.
module tb_sdram_init_refresh_sequencer;
    localparam int IW   = 20;
    localparam int RI   = 50;
    localparam int TRP  = 2;
    localparam int TRFC = 4;
    localparam int TMRD = 2;
    localparam int MAXP = 8;

    localparam logic [2:0] NOP = 3'b111;
    localparam logic [2:0] PRE = 3'b010;
    localparam logic [2:0] REF = 3'b001;
    localparam logic [2:0] LMR = 3'b000;

    typedef struct {
        int          cyc;
        logic [2:0]  code;
        logic [12:0] addr;
        logic [1:0]  ba;
    } cmd_t;

    typedef struct {
        int          cyc;
        logic        ready;
        logic        gnt;
        logic        exp_valid;
        logic [2:0]  exp_code;
        logic [12:0] exp_addr;
        logic        exp_done;
        logic        exp_req;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    cmd_t exp_q[$];
    vec_t vecs[11];

    int pre_t, ref1_t, ref2_t, lmr_t, done_t;
    int done_b, t1, t_sat, g2, pre2, first_ref2, t12, pre3, t13, t14, pre4;

    sdram_init_refresh_sequencer_if sif ();

    sdram_init_refresh_sequencer #(
        .INIT_WAIT_CYCLES(IW),
        .REFRESH_INTERVAL(RI),
        .TRP(TRP),
        .TRFC(TRFC),
        .TMRD(TMRD),
        .INIT_REFRESHES(2),
        .MAX_PENDING(MAXP),
        .MODE_REG(13'h030)
    ) dut (
        .clk(clk),
        .reset(reset),
        .sdram(sif.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic ready, input logic gnt);
        sif.cmd_ready = ready;
        sif.bus_gnt   = gnt;
    endtask

    task automatic pushExpected(input int c, input logic [2:0] code, input logic [12:0] addr);
        cmd_t e;
        e.cyc  = c;
        e.code = code;
        e.addr = addr;
        e.ba   = 2'b00;
        exp_q.push_back(e);
    endtask

    task automatic pushInit(input int lmr_at);
        pushExpected(pre_t, PRE, 13'h400);
        pushExpected(ref1_t, REF, 13'h000);
        pushExpected(ref2_t, REF, 13'h000);
        pushExpected(lmr_at, LMR, 13'h030);
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reset is raised for one edge; the outputs are checked right after that edge.
    task automatic doResetCheck(input string tag);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput({tag, "_valid"}, sif.cmd_valid, 1'b0);
        checkOutput({tag, "_code"}, sif.cmd_code, NOP);
        checkOutput({tag, "_addr"}, sif.cmd_addr, 13'h000);
        checkOutput({tag, "_ba"}, sif.cmd_ba, 2'b00);
        checkOutput({tag, "_req"}, sif.bus_req, 1'b0);
        checkOutput({tag, "_done"}, sif.init_done, 1'b0);
        checkOutput({tag, "_urgent"}, sif.refresh_urgent, 1'b0);
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        cmd_t e;
        if (!reset) begin
            if (sif.cmd_valid && sif.cmd_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_cmd at cycle %0d: got code %b addr 0x%0h, expected none",
                             cyc, sif.cmd_code, sif.cmd_addr);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("cmd_accept", {32'(cyc), sif.cmd_code, sif.cmd_addr, sif.cmd_ba},
                                {32'(e.cyc), e.code, e.addr, e.ba});
                end
            end
            if (!sif.cmd_valid) checkOutput("nop_when_idle", sif.cmd_code, NOP);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        pre_t  = IW;
        ref1_t = pre_t + TRP + 1;
        ref2_t = ref1_t + TRFC + 1;
        lmr_t  = ref2_t + TRFC + 1;
        done_t = lmr_t + TMRD + 1;

        vecs[0]  = '{0,          1'b1, 1'b0, 1'b0, NOP, 13'h000, 1'b0, 1'b0};
        vecs[1]  = '{IW - 1,     1'b1, 1'b0, 1'b0, NOP, 13'h000, 1'b0, 1'b0};
        vecs[2]  = '{pre_t,      1'b1, 1'b0, 1'b1, PRE, 13'h400, 1'b0, 1'b0};
        vecs[3]  = '{pre_t + 1,  1'b1, 1'b0, 1'b0, NOP, 13'h000, 1'b0, 1'b0};
        vecs[4]  = '{ref1_t,     1'b1, 1'b0, 1'b1, REF, 13'h000, 1'b0, 1'b0};
        vecs[5]  = '{ref2_t - 1, 1'b1, 1'b0, 1'b0, NOP, 13'h000, 1'b0, 1'b0};
        vecs[6]  = '{ref2_t,     1'b1, 1'b0, 1'b1, REF, 13'h000, 1'b0, 1'b0};
        vecs[7]  = '{lmr_t,      1'b1, 1'b0, 1'b1, LMR, 13'h030, 1'b0, 1'b0};
        vecs[8]  = '{done_t - 1, 1'b1, 1'b0, 1'b0, NOP, 13'h000, 1'b0, 1'b0};
        vecs[9]  = '{done_t,     1'b1, 1'b0, 1'b0, NOP, 13'h000, 1'b1, 1'b0};
        vecs[10] = '{60,         1'b1, 1'b0, 1'b0, NOP, 13'h000, 1'b1, 1'b0};

        applyStimulus(1'b1, 1'b0);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Run A: plain init against the vector table.
        pushInit(lmr_t);
        for (int i = 0; i < 11; i++) begin
            goto(vecs[i].cyc);
            applyStimulus(vecs[i].ready, vecs[i].gnt);
            @(negedge clk);
            checkOutput("vec_valid", sif.cmd_valid, vecs[i].exp_valid);
            checkOutput("vec_code", sif.cmd_code, vecs[i].exp_code);
            checkOutput("vec_addr", sif.cmd_addr, vecs[i].exp_addr);
            checkOutput("vec_done", sif.init_done, vecs[i].exp_done);
            checkOutput("vec_req", sif.bus_req, vecs[i].exp_req);
            checkOutput("vec_urgent", sif.refresh_urgent, 1'b0);
        end
        checkOutput("sb_drain_a", exp_q.size(), 0);
        doResetCheck("rst_idle");

        // Run B: LOAD_MODE held off for 5 cycles, then refresh traffic.
        pushInit(lmr_t + 5);
        goto(lmr_t);
        applyStimulus(1'b0, 1'b0);
        for (int c = lmr_t; c < lmr_t + 5; c++) begin
            goto(c);
            @(negedge clk);
            checkOutput("bp_valid", sif.cmd_valid, 1'b1);
            checkOutput("bp_cmd", {sif.cmd_code, sif.cmd_addr, sif.cmd_ba}, {LMR, 13'h030, 2'b00});
        end
        goto(lmr_t + 5);
        applyStimulus(1'b1, 1'b0);
        done_b = lmr_t + 5 + TMRD + 1;
        goto(done_b - 1);
        @(negedge clk);
        checkOutput("bp_done_early", sif.init_done, 1'b0);
        goto(done_b);
        @(negedge clk);
        checkOutput("bp_done", sif.init_done, 1'b1);

        // Single refresh: grant arrives 3 cycles after bus_req.
        t1 = done_b + RI - 1;
        goto(t1 + 1);
        @(negedge clk);
        checkOutput("req_before", sif.bus_req, 1'b0);
        goto(t1 + 2);
        @(negedge clk);
        checkOutput("req_rise", sif.bus_req, 1'b1);
        pushExpected(t1 + 6, PRE, 13'h400);
        pushExpected(t1 + 6 + TRP + 1, REF, 13'h000);
        goto(t1 + 5);
        applyStimulus(1'b1, 1'b1);
        goto(t1 + 6 + TRP + 1 + TRFC);
        @(negedge clk);
        checkOutput("req_hold_trfc", sif.bus_req, 1'b1);
        goto(t1 + 6 + TRP + 1 + TRFC + 1);
        applyStimulus(1'b1, 1'b0);
        @(negedge clk);
        checkOutput("req_fall", sif.bus_req, 1'b0);
        goto(t1 + 20);
        @(negedge clk);
        checkOutput("pending_zero", sif.bus_req, 1'b0);
        checkOutput("sb_drain_single", exp_q.size(), 0);

        // Backlog: no grant for many intervals, pending saturates at MAXP.
        t_sat = done_b + (MAXP + 1) * RI - 1;
        goto(t_sat);
        @(negedge clk);
        checkOutput("urgent_before_sat", sif.refresh_urgent, 1'b0);
        goto(t_sat + 1);
        @(negedge clk);
        checkOutput("urgent_sat", sif.refresh_urgent, 1'b1);
        checkOutput("req_waiting", sif.bus_req, 1'b1);
        g2 = done_b + 11 * RI - 1 + 5;
        pre2 = g2 + 1;
        first_ref2 = pre2 + TRP + 1;
        pushExpected(pre2, PRE, 13'h400);
        for (int k = 0; k < MAXP; k++) pushExpected(first_ref2 + k * (TRFC + 1), REF, 13'h000);
        goto(g2);
        applyStimulus(1'b1, 1'b1);
        goto(first_ref2);
        @(negedge clk);
        checkOutput("urgent_hold", sif.refresh_urgent, 1'b1);
        goto(first_ref2 + 1);
        @(negedge clk);
        checkOutput("urgent_clear", sif.refresh_urgent, 1'b0);
        goto(first_ref2 + MAXP * (TRFC + 1) - 1);
        @(negedge clk);
        checkOutput("backlog_req_hold", sif.bus_req, 1'b1);
        goto(first_ref2 + MAXP * (TRFC + 1));
        @(negedge clk);
        checkOutput("backlog_req_fall", sif.bus_req, 1'b0);
        checkOutput("sb_drain_backlog", exp_q.size(), 0);

        // Tick lands on the cycle the REFRESH is accepted; one extra chained REFRESH follows.
        t12  = done_b + 12 * RI - 1;
        pre3 = t12 + 3;
        t13  = done_b + 13 * RI - 1;
        pushExpected(pre3, PRE, 13'h400);
        pushExpected(t13, REF, 13'h000);
        pushExpected(t13 + TRFC + 1, REF, 13'h000);
        goto(pre3 + 1);
        applyStimulus(1'b0, 1'b1);
        goto(t13 - 1);
        @(negedge clk);
        checkOutput("ref_bp_cmd", {sif.cmd_valid, sif.cmd_code}, {1'b1, REF});
        goto(t13);
        applyStimulus(1'b1, 1'b1);
        goto(t13 + 2 * (TRFC + 1) - 1);
        @(negedge clk);
        checkOutput("chain_req_hold", sif.bus_req, 1'b1);
        goto(t13 + 2 * (TRFC + 1));
        @(negedge clk);
        checkOutput("chain_req_fall", sif.bus_req, 1'b0);
        checkOutput("sb_drain_chain", exp_q.size(), 0);

        // Reset while waiting in REF_TRP.
        t14  = done_b + 14 * RI - 1;
        pre4 = t14 + 3;
        pushExpected(pre4, PRE, 13'h400);
        goto(pre4 + 1);
        @(negedge clk);
        checkOutput("in_ref_trp", {sif.bus_req, sif.cmd_valid, sif.init_done}, 3'b101);
        checkOutput("sb_drain_trp", exp_q.size(), 0);
        goto(pre4 + 2);
        doResetCheck("rst_ref_trp");

        // Run C: restart, abort during INIT_TRFC, then a full clean init.
        applyStimulus(1'b1, 1'b0);
        pushExpected(pre_t, PRE, 13'h400);
        pushExpected(ref1_t, REF, 13'h000);
        goto(ref1_t + 2);
        @(negedge clk);
        checkOutput("restart_progress", exp_q.size(), 0);
        goto(ref1_t + 3);
        doResetCheck("rst_init_trfc");
        pushInit(lmr_t);
        goto(done_t - 1);
        @(negedge clk);
        checkOutput("reinit_done_early", sif.init_done, 1'b0);
        goto(done_t);
        @(negedge clk);
        checkOutput("reinit_done", sif.init_done, 1'b1);
        goto(done_t + 4);
        @(negedge clk);
        checkOutput("sb_drain_reinit", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sdram_init_refresh_sequencer.md
Name: sdram_init_refresh_sequencer

Overview:
- Owns SDRAM power-up initialisation and periodic auto-refresh for the 16-bit SDRAM behind the SoC's sdramA port.
- Issues commands on a command bus shared with the main SDRAM access controller.
- Arbitrates for that bus with a req/gnt handshake after init.
- Tracks postponed refreshes and raises an urgent flag when the backlog saturates.

Parameters:
- INIT_WAIT_CYCLES, 5000: power-up idle before the first command (100 us at 50 MHz).
- REFRESH_INTERVAL, 390: cycles between refresh obligations (7.8 us at 50 MHz).
- TRP, 2: cycles waited after an accepted PRECHARGE.
- TRFC, 4: cycles waited after an accepted REFRESH.
- TMRD, 2: cycles waited after an accepted LOAD_MODE.
- INIT_REFRESHES, 2: number of REFRESH commands issued during init.
- MAX_PENDING, 8: saturation value of the postponed-refresh counter.
- MODE_REG, 13'h030: mode register value (CL=3, burst length 1, sequential).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- cmd_valid  out  1  command present.
- cmd_ready  in  1  command bus accepts the command this cycle.
- cmd_code  out  3  {RASn,CASn,WEn}: NOP=111, PRECHARGE=010, REFRESH=001, LOAD_MODE=000.
- cmd_addr  out  13  SDRAM address; bit 10=1 for precharge-all.
- cmd_ba  out  2  bank address.
- bus_req  out  1  request ownership of the command bus (post-init only).
- bus_gnt  in  1  main controller has idled and yielded the bus.
- init_done  out  1  init complete; main controller may issue commands.
- refresh_urgent  out  1  pending == MAX_PENDING.

Behaviour:
- Reset values: cmd_valid=0, cmd_code=111, cmd_addr=0, cmd_ba=0, bus_req=0, init_done=0, refresh_urgent=0.
  - Reset also clears all counters and sets the state to INIT_WAIT.
- Reset mid-operation aborts immediately, including an unaccepted command, and the full init re-runs.
- Command handshake:
  - A command transfers on a cycle with cmd_valid && cmd_ready.
  - cmd_code, cmd_addr and cmd_ba are held stable while cmd_valid=1 and cmd_ready=0.
  - cmd_valid drops the cycle after acceptance.
  - When cmd_valid=0, cmd_code=111.
- Timing waits: the wait counter loads TRP/TRFC/TMRD on acceptance and counts down. The next state is entered when it reaches 0, so the next command is presented no earlier than N+1 cycles after acceptance.
- Init FSM (no bus_req/bus_gnt involvement; init_done=0 throughout):
  - INIT_WAIT: count INIT_WAIT_CYCLES, then go to INIT_PRE.
  - INIT_PRE: PRECHARGE, addr=13'h400, ba=0. Then INIT_TRP.
  - INIT_TRP: wait, then INIT_REF.
  - INIT_REF: REFRESH, addr=0. Then INIT_TRFC.
  - INIT_TRFC: wait. Return to INIT_REF until INIT_REFRESHES have been issued, then INIT_MRS.
  - INIT_MRS: LOAD_MODE, addr=MODE_REG, ba=0. Then INIT_TMRD.
  - INIT_TMRD: wait, then IDLE. init_done rises on entry to IDLE and stays 1 until reset.
- Interval timer:
  - Starts from 0 on entry to IDLE after init and runs freely.
  - On reaching REFRESH_INTERVAL-1 it wraps to 0 and increments pending.
- Pending counter:
  - Width is clog2(MAX_PENDING+1).
  - Incremented by the timer tick; saturates at MAX_PENDING, and a tick at saturation is dropped.
  - Decremented on each accepted post-init REFRESH.
  - A tick and a decrement in the same cycle leave it unchanged.
- refresh_urgent is registered and equals (pending == MAX_PENDING).
- Post-init refresh FSM:
  - IDLE: if pending != 0, go to REQ.
  - REQ: bus_req=1. If bus_gnt is sampled high, go to REF_PRE.
  - REF_PRE: PRECHARGE, addr=13'h400. Then REF_TRP.
  - REF_TRP: wait, then REF_CMD.
  - REF_CMD: REFRESH. Then REF_TRFC.
  - REF_TRFC: wait, then:
    - if pending != 0 and bus_gnt=1, go back to REF_CMD (no second precharge);
    - otherwise go to IDLE and drop bus_req.
- bus_req:
  - Held at 1 from REQ through the final REF_TRFC.
  - Deasserts the cycle the FSM enters IDLE.
  - Never deasserts while cmd_valid=1.
- bus_gnt dropping while in REF_PRE..REF_TRFC does not abort the current command. It only prevents chaining.

Test Plan:
- Init sequence (INIT_WAIT_CYCLES=20, TRP=2, TRFC=4, TMRD=2, cmd_ready=1) -> the only non-NOP commands are: PRECHARGE 400 at cycle 20, REFRESH at 23, REFRESH at 28, LOAD_MODE 030 at 33; init_done=1 at 36.
- cmd_ready backpressure: hold cmd_ready=0 for 5 cycles on LOAD_MODE -> code, addr and ba stay stable; cmd_valid stays 1; the TMRD wait starts only after acceptance.
- Single refresh (REFRESH_INTERVAL=50, bus_gnt granted 3 cycles after bus_req) -> bus_req rises 2 cycles after the tick. The block issues PRECHARGE then REFRESH, and pending returns 0. bus_req falls after the TRFC wait.
- Backlog (bus_gnt held 0 for 10 intervals, MAX_PENDING=8) -> pending saturates at 8 and refresh_urgent=1. After grant, 8 back-to-back REFRESHes are issued with one PRECHARGE; urgent clears once pending < 8.
- Simultaneous tick and REFRESH acceptance -> pending unchanged. The FSM chains one extra REFRESH if bus_gnt is still high.
- Reset asserted during INIT_TRFC and again during REF_TRP -> outputs return to reset values next cycle, and the full init sequence restarts from INIT_WAIT.
